// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and defaults for the IF/DM unified-memory arbiter.
package mem_port_arbiter_pkg;

  localparam int unsigned ADDR_W_DEF  = 32;
  localparam int unsigned DATA_W_DEF  = 32;
  localparam int unsigned TIMEOUT_DEF = 255;
  localparam int unsigned CNT_W       = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GNT_IF = 2'd1,
    GNT_DM = 2'd2,
    RESP   = 2'd3
  } arb_state_e;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_DM = 1'b1;

endpackage

// File: rtl/mem_timeout_counter.sv
// Grant-cycle counter; expire fires in the LIMIT-th cycle of an un-acked grant.
module mem_timeout_counter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned LIMIT = TIMEOUT_DEF
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic expire_c_o
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expire_c_o = enable_i & (count_q == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates instruction-fetch and data-memory ports onto one single-port,
// variable-latency memory; DM has fixed priority, stalls are combinational.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  input  logic              if_flush_i,
  output logic [DATA_W-1:0] if_rdata_o,
  output logic              if_valid_o,
  output logic              if_stall_o,
  input  logic              dm_req_i,
  input  logic              dm_we_i,
  input  logic [ADDR_W-1:0] dm_addr_i,
  input  logic [DATA_W-1:0] dm_wdata_i,
  output logic [DATA_W-1:0] dm_rdata_o,
  output logic              dm_valid_o,
  output logic              dm_stall_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              err_o
);

  arb_state_e        state_q;
  logic              owner_q;
  logic              discard_q;
  logic              mem_req_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic [DATA_W-1:0] if_rdata_q;
  logic [DATA_W-1:0] dm_rdata_q;
  logic              if_valid_q;
  logic              dm_valid_q;
  logic              err_q;

  logic gnt_dm_c;
  logic gnt_if_c;
  logic in_gnt_c;
  logic discard_c;
  logic expire_c;

  // RESP hands the memory straight to the other port; the owner is never re-granted.
  always_comb begin
    gnt_dm_c  = dm_req_i & ((state_q == IDLE) | ((state_q == RESP) & (owner_q == OWN_IF)));
    gnt_if_c  = if_req_i & (((state_q == IDLE) & ~dm_req_i) |
                            ((state_q == RESP) & (owner_q == OWN_DM)));
    in_gnt_c  = (state_q == GNT_IF) | (state_q == GNT_DM);
    discard_c = discard_q | ((state_q == GNT_IF) & if_flush_i);
  end

  mem_timeout_counter #(
    .LIMIT (TIMEOUT)
  ) u_timeout (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .clear_i    (gnt_dm_c | gnt_if_c),
    .enable_i   (in_gnt_c),
    .expire_c_o (expire_c)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= IDLE;
      owner_q     <= OWN_IF;
      discard_q   <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      if_valid_q  <= 1'b0;
      dm_valid_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      if_valid_q <= 1'b0;
      dm_valid_q <= 1'b0;
      case (state_q)
        IDLE, RESP: begin
          discard_q <= 1'b0;
          state_q   <= IDLE;
          if (gnt_dm_c) begin
            state_q     <= GNT_DM;
            owner_q     <= OWN_DM;
            mem_req_q   <= 1'b1;
            mem_we_q    <= dm_we_i;
            mem_addr_q  <= dm_addr_i;
            mem_wdata_q <= dm_wdata_i;
          end else if (gnt_if_c) begin
            state_q     <= GNT_IF;
            owner_q     <= OWN_IF;
            mem_req_q   <= 1'b1;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= if_addr_i;
            mem_wdata_q <= '0;
            discard_q   <= if_flush_i;
          end
        end
        GNT_IF, GNT_DM: begin
          discard_q <= discard_c;
          // A timeout completes the access with zero data so the pipeline drains.
          if (mem_ack_i || expire_c) begin
            state_q   <= RESP;
            mem_req_q <= 1'b0;
            if (!mem_ack_i) begin
              err_q <= 1'b1;
            end
            if (owner_q == OWN_DM) begin
              dm_valid_q <= 1'b1;
              if (!mem_ack_i) begin
                dm_rdata_q <= '0;
              end else if (!mem_we_q) begin
                dm_rdata_q <= mem_rdata_i;
              end
            end else if (!discard_c) begin
              if_valid_q <= 1'b1;
              if_rdata_q <= mem_ack_i ? mem_rdata_i : '0;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign if_stall_o  = if_req_i & ~if_valid_q;
  assign dm_stall_o  = dm_req_i & ~dm_valid_q;
  assign if_rdata_o  = if_rdata_q;
  assign if_valid_o  = if_valid_q;
  assign dm_rdata_o  = dm_rdata_q;
  assign dm_valid_o  = dm_valid_q;
  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter with a variable-latency memory responder.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned TO = 8;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          if_req_i, if_flush_i, dm_req_i, dm_we_i, mem_ack_i;
  logic [AW-1:0] if_addr_i, dm_addr_i;
  logic [DW-1:0] dm_wdata_i, mem_rdata_i;
  logic [DW-1:0] if_rdata_o, dm_rdata_o, mem_wdata_o;
  logic [AW-1:0] mem_addr_o;
  logic          if_valid_o, if_stall_o, dm_valid_o, dm_stall_o;
  logic          mem_req_o, mem_we_o, err_o;

  typedef struct {
    logic        port;
    logic [31:0] data;
  } exp_t;

  exp_t        sb[$];
  int          vectors = 0;
  int          miscompares = 0;
  int          ack_delay = 2;
  bit          mem_en = 1'b1;
  int          rcnt = 0;
  logic [31:0] mem [logic [31:0]];

  always #5 clk_i = ~clk_i;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_flush_i(if_flush_i),
    .if_rdata_o(if_rdata_o), .if_valid_o(if_valid_o), .if_stall_o(if_stall_o),
    .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_addr_i(dm_addr_i), .dm_wdata_i(dm_wdata_i),
    .dm_rdata_o(dm_rdata_o), .dm_valid_o(dm_valid_o), .dm_stall_o(dm_stall_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i),
    .err_o(err_o)
  );

  // Memory: acks ack_delay cycles into a request, tolerates abandoned requests.
  initial begin
    forever begin
      @(negedge clk_i);
      mem_ack_i = 1'b0;
      if (mem_req_o && mem_en) begin
        rcnt++;
        if (rcnt >= ack_delay) begin
          mem_ack_i = 1'b1;
          rcnt = 0;
          if (mem_we_o) begin
            mem[mem_addr_o] = mem_wdata_o;
            mem_rdata_i = 32'hBAD0_BAD0;
          end else begin
            mem_rdata_i = mem.exists(mem_addr_o) ? mem[mem_addr_o] : 32'h0;
          end
        end
      end else begin
        rcnt = 0;
      end
    end
  end

  task automatic wait_valid(input logic port, input int budget, output bit seen);
    seen = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk_i);
      #1;
      if ((port == OWN_DM) ? dm_valid_o : if_valid_o) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst_i = 1'b1; if_req_i = 1'b1; dm_req_i = 1'b0; dm_we_i = 1'b0; if_flush_i = 1'b0;
    if_addr_i = '0; dm_addr_i = '0; dm_wdata_i = '0; mem_ack_i = 1'b0; mem_rdata_i = '0;
    #1 rst_i = 1'b0;
    #1;
    vectors++;
    if ({mem_req_o, mem_we_o, if_valid_o, dm_valid_o, err_o} !== 5'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl: got %b required 00000", {mem_req_o, mem_we_o, if_valid_o, dm_valid_o, err_o});
    end
    vectors++;
    if ({mem_addr_o, mem_wdata_o, if_rdata_o, dm_rdata_o} !== 128'h0) begin
      miscompares++;
      $display("FAIL reset_data: got %h %h %h %h required all 0", mem_addr_o, mem_wdata_o, if_rdata_o, dm_rdata_o);
    end
    vectors++;
    if ({if_stall_o, dm_stall_o} !== 2'b10) begin
      miscompares++;
      $display("FAIL reset_stall: got %b required 10", {if_stall_o, dm_stall_o});
    end
    repeat (2) @(negedge clk_i);
    #1;
    vectors++;
    if (mem_req_o !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_hold_req: got %b required 0", mem_req_o);
    end
    if_req_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b1;
  endtask

  task automatic test_if_fetch;
    exp_t e;
    bit   seen = 1'b0;
    int   lat = 0;
    @(negedge clk_i);
    if_req_i = 1'b1; if_addr_i = 32'h10;
    sb.push_back('{OWN_IF, 32'h8C01_0004});
    for (int c = 0; c < 40; c++) begin
      @(negedge clk_i);
      #1;
      lat = c + 1;
      if (if_valid_o) begin seen = 1'b1; break; end
      vectors++;
      if (if_stall_o !== 1'b1 || (mem_req_o && mem_we_o !== 1'b0)) begin
        miscompares++;
        $display("FAIL if_wait: stall=%b we=%b required stall=1 we=0", if_stall_o, mem_we_o);
      end
    end
    vectors++;
    if (!seen || lat != 3) begin
      miscompares++;
      $display("FAIL if_latency: seen=%0d cycles=%0d required 3", seen, lat);
    end
    vectors++;
    if (if_stall_o !== 1'b0 || mem_we_o !== 1'b0) begin
      miscompares++;
      $display("FAIL if_done: stall=%b we=%b required 0 0", if_stall_o, mem_we_o);
    end
    if (seen && sb.size() > 0) begin
      e = sb.pop_front();
      vectors++;
      if (e.port !== OWN_IF || if_rdata_o !== e.data) begin
        miscompares++;
        $display("FAIL if_data: got %h required %h", if_rdata_o, e.data);
      end
    end
    if_req_i = 1'b0;
    @(negedge clk_i);
    #1;
    vectors++;
    if (if_valid_o !== 1'b0) begin
      miscompares++;
      $display("FAIL if_pulse: got %b required 0", if_valid_o);
    end
  endtask

  task automatic test_dm_priority;
    exp_t e;
    bit   seen;
    @(negedge clk_i);
    dm_req_i = 1'b1; dm_we_i = 1'b0; dm_addr_i = 32'h40;
    if_req_i = 1'b1; if_addr_i = 32'h14;
    sb.push_back('{OWN_DM, 32'hCAFE_F00D});
    sb.push_back('{OWN_IF, 32'h0022_1820});
    @(negedge clk_i);
    #1;
    vectors++;
    if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h40 || mem_we_o !== 1'b0) begin
      miscompares++;
      $display("FAIL prio_first: req=%b addr=%h we=%b required 1 00000040 0", mem_req_o, mem_addr_o, mem_we_o);
    end
    wait_valid(OWN_DM, 40, seen);
    vectors++;
    if (!seen) begin
      miscompares++;
      $display("FAIL prio_dm_timeout: dm_valid_o never rose");
    end else begin
      e = sb.pop_front();
      if (e.port !== OWN_DM || dm_rdata_o !== e.data) begin
        miscompares++;
        $display("FAIL prio_dm_data: got %h required %h", dm_rdata_o, e.data);
      end
    end
    dm_req_i = 1'b0;
    @(negedge clk_i);
    #1;
    vectors++;
    if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h14) begin
      miscompares++;
      $display("FAIL prio_if_from_resp: req=%b addr=%h required 1 00000014", mem_req_o, mem_addr_o);
    end
    wait_valid(OWN_IF, 40, seen);
    vectors++;
    if (!seen) begin
      miscompares++;
      $display("FAIL prio_if_timeout: if_valid_o never rose");
    end else begin
      e = sb.pop_front();
      if (e.port !== OWN_IF || if_rdata_o !== e.data) begin
        miscompares++;
        $display("FAIL prio_if_data: got %h required %h", if_rdata_o, e.data);
      end
    end
    if_req_i = 1'b0;
  endtask

  task automatic test_dm_store;
    exp_t e;
    bit   seen = 1'b0;
    ack_delay = 3;
    @(negedge clk_i);
    dm_req_i = 1'b1; dm_we_i = 1'b1; dm_addr_i = 32'h80; dm_wdata_i = 32'hDEAD_BEEF;
    sb.push_back('{OWN_DM, 32'hCAFE_F00D});
    for (int c = 0; c < 40; c++) begin
      @(negedge clk_i);
      #1;
      if (dm_valid_o) begin seen = 1'b1; break; end
      if (mem_req_o) begin
        vectors++;
        if ({mem_we_o, mem_wdata_o, mem_addr_o} !== {1'b1, 32'hDEAD_BEEF, 32'h80}) begin
          miscompares++;
          $display("FAIL store_hold: we=%b wdata=%h addr=%h required 1 deadbeef 00000080", mem_we_o, mem_wdata_o, mem_addr_o);
        end
      end
    end
    vectors++;
    if (!seen) begin
      miscompares++;
      $display("FAIL store_timeout: dm_valid_o never rose");
    end else begin
      e = sb.pop_front();
      if (dm_rdata_o !== e.data) begin
        miscompares++;
        $display("FAIL store_rdata_kept: got %h required %h", dm_rdata_o, e.data);
      end
    end
    dm_req_i = 1'b0; dm_we_i = 1'b0;
    @(negedge clk_i);
    #1;
    vectors++;
    if (dm_valid_o !== 1'b0) begin
      miscompares++;
      $display("FAIL store_pulse: got %b required 0", dm_valid_o);
    end
    ack_delay = 2;
    dm_req_i = 1'b1; dm_addr_i = 32'h80;
    sb.push_back('{OWN_DM, 32'hDEAD_BEEF});
    wait_valid(OWN_DM, 40, seen);
    vectors++;
    if (!seen) begin
      miscompares++;
      $display("FAIL store_readback_timeout: dm_valid_o never rose");
    end else begin
      e = sb.pop_front();
      if (dm_rdata_o !== e.data) begin
        miscompares++;
        $display("FAIL store_readback: got %h required %h", dm_rdata_o, e.data);
      end
    end
    dm_req_i = 1'b0;
  endtask

  task automatic test_flush;
    exp_t e;
    bit   seen = 1'b0;
    bit   dropped = 1'b0;
    logic prev_req = 1'b1;
    ack_delay = 3;
    @(negedge clk_i);
    if_req_i = 1'b1; if_addr_i = 32'h20;
    sb.push_back('{OWN_IF, 32'hAC03_0008});
    @(negedge clk_i);
    if_flush_i = 1'b1; if_addr_i = 32'h24;
    @(negedge clk_i);
    if_flush_i = 1'b0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk_i);
      #1;
      if (if_valid_o) begin seen = 1'b1; break; end
      if (prev_req && !mem_req_o && !dropped) begin
        dropped = 1'b1;
        vectors++;
        if (if_rdata_o !== 32'h0022_1820 || mem_addr_o !== 32'h20) begin
          miscompares++;
          $display("FAIL flush_discard: rdata=%h addr=%h required 00221820 00000020", if_rdata_o, mem_addr_o);
        end
      end
      prev_req = mem_req_o;
    end
    vectors++;
    if (!dropped || !seen) begin
      miscompares++;
      $display("FAIL flush_sequence: flushed_done=%0d refetch_valid=%0d required 1 1", dropped, seen);
    end else begin
      e = sb.pop_front();
      if (if_rdata_o !== e.data || mem_addr_o !== 32'h24) begin
        miscompares++;
        $display("FAIL flush_refetch: data=%h addr=%h required %h 00000024", if_rdata_o, mem_addr_o, e.data);
      end
    end
    if_req_i = 1'b0;
    ack_delay = 2;
  endtask

  task automatic test_timeout;
    exp_t e;
    bit   seen = 1'b0;
    int   req_cycles = 0;
    mem_en = 1'b0;
    @(negedge clk_i);
    dm_req_i = 1'b1; dm_we_i = 1'b0; dm_addr_i = 32'h44;
    sb.push_back('{OWN_DM, 32'h0});
    for (int c = 0; c < 40; c++) begin
      @(negedge clk_i);
      #1;
      if (dm_valid_o) begin seen = 1'b1; break; end
      if (mem_req_o) req_cycles++;
    end
    vectors++;
    if (!seen || req_cycles != int'(TO)) begin
      miscompares++;
      $display("FAIL timeout_cycles: seen=%0d req_cycles=%0d required 1 %0d", seen, req_cycles, TO);
    end
    vectors++;
    if (err_o !== 1'b1 || mem_req_o !== 1'b0) begin
      miscompares++;
      $display("FAIL timeout_err: err=%b req=%b required 1 0", err_o, mem_req_o);
    end
    if (seen) begin
      e = sb.pop_front();
      vectors++;
      if (dm_rdata_o !== e.data) begin
        miscompares++;
        $display("FAIL timeout_rdata: got %h required %h", dm_rdata_o, e.data);
      end
    end
    dm_req_i = 1'b0;
    repeat (2) @(negedge clk_i);
    #1;
    vectors++;
    if (err_o !== 1'b1 || dm_valid_o !== 1'b0) begin
      miscompares++;
      $display("FAIL timeout_sticky: err=%b valid=%b required 1 0", err_o, dm_valid_o);
    end
    mem_en = 1'b1;
  endtask

  task automatic test_reset_mid_access;
    exp_t e;
    bit   seen;
    ack_delay = 6;
    @(negedge clk_i);
    dm_req_i = 1'b1; dm_we_i = 1'b0; dm_addr_i = 32'h40;
    @(negedge clk_i);
    #1;
    vectors++;
    if (mem_req_o !== 1'b1) begin
      miscompares++;
      $display("FAIL rstmid_pre: req=%b required 1", mem_req_o);
    end
    @(negedge clk_i);
    if_req_i = 1'b1; if_addr_i = 32'h10;
    #2 rst_i = 1'b0;
    #1;
    vectors++;
    if ({mem_req_o, dm_valid_o, if_valid_o, err_o, dm_stall_o} !== 5'b00001) begin
      miscompares++;
      $display("FAIL rstmid_async: req,dv,iv,err,dstall=%b required 00001", {mem_req_o, dm_valid_o, if_valid_o, err_o, dm_stall_o});
    end
    dm_req_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b1;
    ack_delay = 2;
    sb.push_back('{OWN_IF, 32'h8C01_0004});
    wait_valid(OWN_IF, 40, seen);
    vectors++;
    if (!seen) begin
      miscompares++;
      $display("FAIL rstmid_if_timeout: if_valid_o never rose");
    end else begin
      e = sb.pop_front();
      if (if_rdata_o !== e.data) begin
        miscompares++;
        $display("FAIL rstmid_if_data: got %h required %h", if_rdata_o, e.data);
      end
    end
    if_req_i = 1'b0;
  endtask

  initial begin
    mem[32'h10] = 32'h8C01_0004;
    mem[32'h14] = 32'h0022_1820;
    mem[32'h20] = 32'h1111_0000;
    mem[32'h24] = 32'hAC03_0008;
    mem[32'h40] = 32'hCAFE_F00D;
    mem[32'h44] = 32'h55AA_55AA;
    test_reset();
    test_if_fetch();
    test_dm_priority();
    test_dm_store();
    test_flush();
    test_timeout();
    test_reset_mid_access();
    repeat (2) @(negedge clk_i);
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port, variable-latency unified memory between the pipeline's instruction-fetch (IF) port and data-memory (DM) port.
- Sits between the PC/Instruction_Memory path and the MEM stage on one side and the backing memory on the other.
- Sequences each access with a req/ack handshake to memory.
- Generates per-port stall signals that freeze PC, IF/ID and the later pipeline registers until that port's access completes.

Parameters:
ADDR_W, 32, address width of both ports and memory
DATA_W, 32, data width
TIMEOUT, 255, max cycles a granted access waits for mem_ack_i before abort (8-bit counter)

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  reset, asynchronous, active-low
if_req_i  in  1  fetch request, held until if_stall_o low
if_addr_i  in  ADDR_W  fetch address
if_flush_i  in  1  branch/jump taken; discard outstanding fetch
if_rdata_o  out  DATA_W  fetched instruction, valid with if_valid_o
if_valid_o  out  1  one-cycle completion pulse
if_stall_o  out  1  if_req_i & ~if_valid_o
dm_req_i  in  1  data request (memread|memwrite), held until dm_stall_o low
dm_we_i  in  1  1 = write
dm_addr_i  in  ADDR_W  data address
dm_wdata_i  in  DATA_W  store data
dm_rdata_o  out  DATA_W  load data, valid with dm_valid_o
dm_valid_o  out  1  one-cycle completion pulse
dm_stall_o  out  1  dm_req_i & ~dm_valid_o
mem_req_o  out  1  memory request, held until ack
mem_we_o  out  1  memory write enable
mem_addr_o  out  ADDR_W  memory address
mem_wdata_o  out  DATA_W  memory write data
mem_ack_i  in  1  memory completion; rdata valid same cycle
mem_rdata_i  in  DATA_W  memory read data
err_o  out  1  sticky timeout flag

Behaviour:
- Reset (rst_i=0, asynchronous):
  - State goes to IDLE.
  - All registered outputs are 0: mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, if_rdata_o, dm_rdata_o, if_valid_o, dm_valid_o, err_o.
  - Discard flag and timeout counter are 0.
  - Stall outputs stay combinational, so they equal the requests during reset.
- States: IDLE, GNT_IF, GNT_DM, RESP.
  - A 1-bit owner register records which port was granted.
- IDLE:
  - dm_req_i=1 -> GNT_DM; DM has fixed priority because it is the older instruction.
  - else if_req_i=1 -> GNT_IF.
  - else stay in IDLE.
- Grant:
  - On entry, mem_req_o=1 and the owner's addr/we/wdata are latched into mem_*_o.
  - These stay stable until ack.
  - IF accesses always drive mem_we_o=0.
- GNT_x:
  - The counter increments each cycle.
  - mem_ack_i=1 -> RESP. At the same edge, mem_req_o=0 and mem_rdata_i is captured into the owner's rdata_o (writes leave rdata unchanged).
- RESP (1 cycle):
  - The owner's valid_o=1 unless it is suppressed by the discard flag.
  - If the non-owner port requests -> grant it directly (GNT_x).
  - Otherwise -> IDLE.
  - The owner's req, still high in this cycle, is never re-granted from RESP.
- Latency: request seen in IDLE at cycle N -> mem_req_o high at N+1 -> ack at cycle M (M>=N+1) -> valid at M+1. Minimum 3 cycles per access.
- Flush:
  - if_flush_i=1 while in GNT_IF, or in the same cycle IF is granted, sets the discard flag.
  - The memory transaction still completes, because the memory request must not be withdrawn.
  - if_valid_o is suppressed and if_rdata_o is not updated.
  - The flag clears on leaving RESP.
  - if_flush_i has no effect in other states.
- Timeout:
  - If the counter reaches TIMEOUT without ack, set err_o (sticky until reset) and drop mem_req_o.
  - Go to RESP with the owner's rdata_o=0 and valid_o=1, so the pipeline does not deadlock.
  - The counter clears on every grant.
- Simultaneous if_req_i and dm_req_i in IDLE -> DM first. IF is served from DM's RESP cycle.
- Reset mid-access: mem_req_o drops immediately and the partial transaction is abandoned. The memory model must tolerate this.

Decomposition:
- Shared package holds:
  - the state enum (IDLE, GNT_IF, GNT_DM, RESP);
  - owner encoding OWN_IF=0, OWN_DM=1;
  - TIMEOUT default.
- One natural sub-module: mem_timeout_counter (clear/enable/expire). Everything else stays flat.

Test Plan:
- IF-only fetch at 0x00000010, memory acks 2 cycles after mem_req_o with 0x8C010004 -> if_valid_o pulses once, if_rdata_o=0x8C010004, if_stall_o high until that cycle, mem_we_o=0 throughout.
- if_req_i and dm_req_i (load 0x40) raised in the same cycle -> mem_addr_o=0x40 first. dm_valid_o, then IF is granted straight from RESP with no IDLE cycle.
- DM store 0xDEADBEEF to 0x80 -> mem_we_o=1, mem_wdata_o=0xDEADBEEF held until ack. dm_valid_o pulses, dm_rdata_o unchanged.
- if_flush_i pulsed 1 cycle after the IF grant -> transaction completes on ack, if_valid_o stays 0, if_rdata_o keeps its old value; the next fetch to the new PC is served normally.
- mem_ack_i never asserted with TIMEOUT=8 -> mem_req_o drops after 8 grant cycles, err_o=1 sticky, owner valid_o=1 with rdata 0.
- rst_i driven low while in GNT_DM -> mem_req_o, valid outputs and err_o go 0 with no clock edge. After release, a pending if_req_i is granted normally.
